serial_divider: RTL and testbench

//  Sequential restoring divider; arithmetic inverse of the SPM serial-parallel multiplier.

---
 rtl/sdiv_pkg.sv | 13 +
 rtl/sdiv_step.sv | 22 ++
 rtl/serial_divider.sv | 140 ++++++++++++++
 tb/tb_serial_divider.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/sdiv_pkg.sv
// Shared state encoding and default widths for the serial restoring divider.
package sdiv_pkg;

    localparam int unsigned SDIV_DW = 16;
    localparam int unsigned SDIV_VW = 8;

    typedef enum logic [1:0] {
        SDIV_IDLE = 2'd0,
        SDIV_CALC = 2'd1,
        SDIV_DONE = 2'd2
    } sdiv_state_e;

endpackage

// File: rtl/sdiv_step.sv
// One restoring division step: shift in the next dividend bit, compare, conditionally subtract.
module sdiv_step #(
    parameter int unsigned VW = 8
) (
    input  logic [VW:0]   p,
    input  logic          qmsb,
    input  logic [VW-1:0] divisor,
    output logic [VW:0]   p_next,
    output logic          qbit
);

    logic [VW:0] p_sh;
    logic [VW:0] dvs_ext;

    always_comb begin
        p_sh    = {p[VW-1:0], qmsb};
        dvs_ext = {1'b0, divisor};
        qbit    = (p_sh >= dvs_ext);
        p_next  = qbit ? (p_sh - dvs_ext) : p_sh;
    end

endmodule

// File: rtl/serial_divider.sv
// Sequential restoring divider, one quotient bit per clock, MSB first.
// Define SDIV_SIGNED_EN for two's-complement operands (truncating toward zero).
module serial_divider
    import sdiv_pkg::*;
#(
    parameter int unsigned DW = SDIV_DW,
    parameter int unsigned VW = SDIV_VW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [DW-1:0] dividend,
    input  logic [VW-1:0] divisor,
    output logic          busy,
    output logic          done,
    output logic          div0,
    output logic [DW-1:0] quot,
    output logic [VW-1:0] rem
);

    localparam int unsigned CW = (DW > 1) ? $clog2(DW) : 1;

    sdiv_state_e   state;
    sdiv_state_e   state_n;
    logic [VW:0]   p;
    logic [DW-1:0] q;
    logic [VW-1:0] dvs;
    logic [CW-1:0] cnt;

    logic          accept;
    logic          last_step;
    logic [VW:0]   p_next;
    logic          qbit;
    logic [DW-1:0] quot_raw;
    logic [VW-1:0] rem_raw;
    logic [DW-1:0] quot_fix;
    logic [VW-1:0] rem_fix;
    logic [DW-1:0] dividend_mag;
    logic [VW-1:0] divisor_mag;

    sdiv_step #(.VW(VW)) u_step (
        .p       (p),
        .qmsb    (q[DW-1]),
        .divisor (dvs),
        .p_next  (p_next),
        .qbit    (qbit)
    );

    assign accept    = start && (state != SDIV_CALC);
    assign last_step = (cnt == CW'(DW - 1));
    assign quot_raw  = {q[DW-2:0], qbit};
    assign rem_raw   = p_next[VW-1:0];

`ifdef SDIV_SIGNED_EN
    logic          neg_q;
    logic          neg_r;
    logic [VW-1:0] dvd_lo;

    // Magnitudes of the minimum values still fit the unsigned widths.
    assign dividend_mag = dividend[DW-1] ? DW'(~dividend + DW'(1)) : dividend;
    assign divisor_mag  = divisor[VW-1]  ? VW'(~divisor + VW'(1))  : divisor;

    always_comb begin
        quot_fix = quot_raw;
        rem_fix  = rem_raw;
        if (dvs == '0) begin
            quot_fix = '1;
            rem_fix  = dvd_lo;
        end else begin
            if (neg_q) quot_fix = DW'(~quot_raw + DW'(1));
            if (neg_r) rem_fix  = VW'(~rem_raw + VW'(1));
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            dvd_lo <= '0;
        end else if (accept) begin
            neg_q  <= dividend[DW-1] ^ divisor[VW-1];
            neg_r  <= dividend[DW-1];
            dvd_lo <= dividend[VW-1:0];
        end
    end
`else
    assign dividend_mag = dividend;
    assign divisor_mag  = divisor;
    assign quot_fix     = quot_raw;
    assign rem_fix      = rem_raw;
`endif

    // Next-state logic
    always_comb begin
        state_n = state;
        case (state)
            SDIV_IDLE: if (start) state_n = SDIV_CALC;
            SDIV_CALC: if (last_step) state_n = SDIV_DONE;
            SDIV_DONE: state_n = start ? SDIV_CALC : SDIV_IDLE;
            default:   state_n = SDIV_IDLE;
        endcase
    end

    // State, datapath and registered outputs
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= SDIV_IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            div0  <= 1'b0;
            quot  <= '0;
            rem   <= '0;
            p     <= '0;
            q     <= '0;
            dvs   <= '0;
            cnt   <= '0;
        end else begin
            state <= state_n;
            busy  <= (state_n == SDIV_CALC);
            done  <= (state_n == SDIV_DONE);
            if (accept) begin
                p    <= '0;
                q    <= dividend_mag;
                dvs  <= divisor_mag;
                cnt  <= '0;
                div0 <= 1'b0;
            end else if (state == SDIV_CALC) begin
                p   <= p_next;
                q   <= quot_raw;
                cnt <= cnt + CW'(1);
                if (last_step) begin
                    quot <= quot_fix;
                    rem  <= rem_fix;
                    div0 <= (dvs == '0);
                end
            end
        end
    end

endmodule

// File: tb/tb_serial_divider.sv
// Self-checking bench for serial_divider: vector table plus reset/abort/busy/back-to-back sequences.
module tb_serial_divider;

    localparam int unsigned DW = 16;
    localparam int unsigned VW = 8;

    logic          clk;
    logic          rst;
    logic          start;
    logic [DW-1:0] dividend;
    logic [VW-1:0] divisor;
    logic          busy;
    logic          done;
    logic          div0;
    logic [DW-1:0] quot;
    logic [VW-1:0] rem;

    int checks;
    int errors;

    typedef struct {
        logic [DW-1:0] a;
        logic [VW-1:0] b;
        logic [DW-1:0] eq;
        logic [VW-1:0] er;
        logic          ed;
    } vec_t;

    vec_t vecs[$];

    serial_divider #(.DW(DW), .VW(VW)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .dividend (dividend),
        .divisor  (divisor),
        .busy     (busy),
        .done     (done),
        .div0     (div0),
        .quot     (quot),
        .rem      (rem)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Present operands with start for one edge; returns #1 after the accept edge.
    task automatic launch(input logic [DW-1:0] a, input logic [VW-1:0] b);
        @(negedge clk);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start    = 1'b0;
        dividend = DW'($urandom);
        divisor  = VW'($urandom);
    endtask

    // n0 = edges already elapsed since the accept edge.
    task automatic wait_done(input string name, input int n0, input logic [DW-1:0] eq,
                             input logic [VW-1:0] er, input logic ed);
        int n;
        n = n0;
        while (!done && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk({name, "_latency"}, 32'(n), 32'(DW));
        chk({name, "_quot"}, 32'(quot), 32'(eq));
        chk({name, "_rem"}, 32'(rem), 32'(er));
        chk({name, "_div0"}, 32'(div0), 32'(ed));
        chk({name, "_busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int seen;
        checks   = 0;
        errors   = 0;
        rst      = 1'b0;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;

`ifdef SDIV_SIGNED_EN
        vecs.push_back('{16'hFE04, 8'h0D, 16'hFFD9, 8'hFF, 1'b0});
        vecs.push_back('{16'h8000, 8'hFF, 16'h8000, 8'h00, 1'b0});
        vecs.push_back('{16'h01FB, 8'h0D, 16'h0027, 8'h00, 1'b0});
        vecs.push_back('{16'h0064, 8'hF9, 16'hFFF2, 8'h02, 1'b0});
        vecs.push_back('{16'hFF9C, 8'hF9, 16'h000E, 8'hFE, 1'b0});
        vecs.push_back('{16'h1234, 8'h00, 16'hFFFF, 8'h34, 1'b1});
        vecs.push_back('{16'h0000, 8'h05, 16'h0000, 8'h00, 1'b0});
`else
        vecs.push_back('{16'h01FB, 8'h0D, 16'h0027, 8'h00, 1'b0});
        vecs.push_back('{16'h01FB, 8'h27, 16'h000D, 8'h00, 1'b0});
        vecs.push_back('{16'h01FC, 8'h0D, 16'h0027, 8'h01, 1'b0});
        vecs.push_back('{16'hFFFF, 8'h01, 16'hFFFF, 8'h00, 1'b0});
        vecs.push_back('{16'h1234, 8'h00, 16'hFFFF, 8'h34, 1'b1});
        vecs.push_back('{16'h0000, 8'h05, 16'h0000, 8'h00, 1'b0});
        vecs.push_back('{16'hFFFF, 8'hFF, 16'h0101, 8'h00, 1'b0});
        vecs.push_back('{16'h03E8, 8'h07, 16'h008E, 8'h06, 1'b0});
        vecs.push_back('{16'h0064, 8'hC8, 16'h0000, 8'h64, 1'b0});
`endif

        // Reset held for three cycles
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_div0", 32'(div0), 32'd0);
        chk("rst_quot", 32'(quot), 32'd0);
        chk("rst_rem", 32'(rem), 32'd0);
        rst = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            launch(vecs[i].a, vecs[i].b);
            chk($sformatf("v%0d_busy_after_accept", i), 32'(busy), 32'd1);
            wait_done($sformatf("v%0d", i), 0, vecs[i].eq, vecs[i].er, vecs[i].ed);
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_done_pulse", i), 32'(done), 32'd0);
            chk($sformatf("v%0d_quot_hold", i), 32'(quot), 32'(vecs[i].eq));
        end

        // Start while busy must be ignored
        launch(16'h01FC, 8'h0D);
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        dividend = 16'h0010;
        divisor  = 8'h02;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done("busy_ignore", 4, 16'h0027, 8'h01, 1'b0);

        // Start accepted while in DONE: back-to-back operation
        launch(16'h03E8, 8'h07);
        chk("b2b_done_drop", 32'(done), 32'd0);
        chk("b2b_busy", 32'(busy), 32'd1);
        chk("b2b_div0_clear", 32'(div0), 32'd0);
        wait_done("b2b", 0, 16'h008E, 8'h06, 1'b0);

        // Reset mid-operation aborts without a done pulse
        launch(16'h1234, 8'h00);
        repeat (7) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_div0", 32'(div0), 32'd0);
        chk("abort_quot", 32'(quot), 32'd0);
        chk("abort_rem", 32'(rem), 32'd0);
        @(negedge clk);
        rst  = 1'b1;
        seen = 0;
        repeat (24) begin
            @(posedge clk);
            #1;
            if (done) seen++;
        end
        chk("abort_no_done", 32'(seen), 32'd0);
        launch(16'h01FB, 8'h0D);
        wait_done("after_abort", 0, 16'h0027, 8'h00, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, got hang expected finish");
        $fatal(1);
    end

endmodule
